// File: rtl/cnt10_trap_monitor.sv
// Trap driver and sequence checker for a decade counter: follows Q through the
// 0..9 wrap sequence, arms on ARM_VAL and requests a trap (TEST) on TRAP_VAL.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | monitor disabled, waiting for en_i
// SYNC     | take Q as baseline without checking (start-up or after error)
// WAIT_ARM | checking sequence, waiting for Q == ARM_VAL
// ARMED    | checking sequence, TEST fires when Q == TRAP_VAL
// DONE     | single-shot trap spent; checking continues, TEST held low
module cnt10_trap_monitor #(
  parameter int unsigned ARM_VAL  = 9,
  parameter int unsigned TRAP_VAL = 1,
  parameter bit          REARM    = 1'b1,
  parameter int unsigned WRAP_W   = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic [3:0]        q_i,
  output logic              test_o,
  output logic              seq_err_o,
  output logic              illegal_o,
  output logic [WRAP_W-1:0] wrap_cnt_o,
  output logic [2:0]        state_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SYNC     = 3'd1;
  localparam logic [2:0] WAIT_ARM = 3'd2;
  localparam logic [2:0] ARMED    = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam logic [3:0]        ARM_Q    = 4'(ARM_VAL);
  localparam logic [3:0]        TRAP_Q   = 4'(TRAP_VAL);
  localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_q, state_d;
  logic [3:0]        q_prev_q, q_prev_d;
  logic              seq_err_q, seq_err_d;
  logic              illegal_q, illegal_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              skip_q, skip_d;

  logic [3:0] expected;
  logic       checking;
  logic       seq_fail;
  logic       test;

  assign expected = (q_prev_q == 4'd9) ? 4'd0 : q_prev_q + 4'd1;
  assign checking = (state_q == WAIT_ARM) || (state_q == ARMED) || (state_q == DONE);
  // The counter may jump or hold after a trap, so that cycle only re-baselines.
  assign seq_fail = checking && !skip_q && (q_i != expected);

  always_comb begin
    state_d   = state_q;
    q_prev_d  = q_prev_q;
    seq_err_d = seq_err_q;
    illegal_d = illegal_q;
    wrap_d    = wrap_q;
    skip_d    = 1'b0;
    test      = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      q_prev_d = q_i;
      if (q_i > 4'd9) begin
        illegal_d = 1'b1;
        state_d   = SYNC;
      end else if (seq_fail) begin
        seq_err_d = 1'b1;
        state_d   = SYNC;
      end else begin
        if (checking && !skip_q && (q_prev_q == 4'd9) && (q_i == 4'd0) && (wrap_q != '1))
          wrap_d = wrap_q + WRAP_ONE;
        case (state_q)
          IDLE:     state_d = SYNC;
          SYNC:     state_d = (q_i == ARM_Q) ? ARMED : WAIT_ARM;
          WAIT_ARM: if (q_i == ARM_Q) state_d = ARMED;
          ARMED: begin
            if (q_i == TRAP_Q) begin
              test    = 1'b1;
              skip_d  = 1'b1;
              state_d = REARM ? WAIT_ARM : DONE;
            end
          end
          DONE:     state_d = DONE;
          default:  state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      q_prev_q  <= 4'd0;
      seq_err_q <= 1'b0;
      illegal_q <= 1'b0;
      wrap_q    <= '0;
      skip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_prev_q  <= q_prev_d;
      seq_err_q <= seq_err_d;
      illegal_q <= illegal_d;
      wrap_q    <= wrap_d;
      skip_q    <= skip_d;
    end
  end

  assign test_o     = test;
  assign seq_err_o  = seq_err_q;
  assign illegal_o  = illegal_q;
  assign wrap_cnt_o = wrap_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_cnt10_trap_monitor.sv
// Directed bench for cnt10_trap_monitor: a re-arming instance and a single-shot
// instance with a 2-bit wrap counter share stimulus; a scoreboard checks each cycle.
module tb_cnt10_trap_monitor;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] q;

  logic       test_a, seq_a, ill_a;
  logic [7:0] wrap_a;
  logic [2:0] st_a;
  logic       test_b, seq_b, ill_b;
  logic [1:0] wrap_b;
  logic [2:0] st_b;

  cnt10_trap_monitor #(.ARM_VAL(9), .TRAP_VAL(1), .REARM(1'b1), .WRAP_W(8)) dut (
    .clk_i(clk), .reset_i(rst), .en_i(en), .q_i(q),
    .test_o(test_a), .seq_err_o(seq_a), .illegal_o(ill_a),
    .wrap_cnt_o(wrap_a), .state_o(st_a)
  );

  cnt10_trap_monitor #(.ARM_VAL(9), .TRAP_VAL(1), .REARM(1'b0), .WRAP_W(2)) dut_nr (
    .clk_i(clk), .reset_i(rst), .en_i(en), .q_i(q),
    .test_o(test_b), .seq_err_o(seq_b), .illegal_o(ill_b),
    .wrap_cnt_o(wrap_b), .state_o(st_b)
  );

  typedef struct {
    bit         sel;
    int         step_no;
    logic       test;
    logic [2:0] st;
    logic       seq;
    logic       ill;
    logic [7:0] wrap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input int n, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, n, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (!e.sel) begin
        cmp("test",    e.step_no, {7'd0, test_a}, {7'd0, e.test});
        cmp("state",   e.step_no, {5'd0, st_a},   {5'd0, e.st});
        cmp("seq_err", e.step_no, {7'd0, seq_a},  {7'd0, e.seq});
        cmp("illegal", e.step_no, {7'd0, ill_a},  {7'd0, e.ill});
        cmp("wrap",    e.step_no, wrap_a,         e.wrap);
      end else begin
        cmp("nr_test",    e.step_no, {7'd0, test_b}, {7'd0, e.test});
        cmp("nr_state",   e.step_no, {5'd0, st_b},   {5'd0, e.st});
        cmp("nr_seq_err", e.step_no, {7'd0, seq_b},  {7'd0, e.seq});
        cmp("nr_illegal", e.step_no, {7'd0, ill_b},  {7'd0, e.ill});
        cmp("nr_wrap",    e.step_no, {6'd0, wrap_b}, e.wrap);
      end
    end
  end

  task automatic step(input logic r, input logic e, input logic [3:0] qv, input bit s,
                      input logic t, input logic [2:0] st, input logic se, input logic il,
                      input logic [7:0] w);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r;
    en  = e;
    q   = qv;
    x.sel = s; x.step_no = step_cnt; x.test = t; x.st = st;
    x.seq = se; x.ill = il; x.wrap = w;
    exp_q.push_back(x);
    step_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    q   = 4'd0;

    // Reset, then a clean 0..9,0,1 run: arm at 9, trap at the next 1.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 8, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 9; i++) step(0, 1, 4'(i), 0, 0, 2, 0, 0, 0);
    step(0, 1, 0, 0, 0, 3, 0, 0, 0);
    step(0, 1, 1, 0, 1, 3, 0, 0, 1);

    // Jump to 5 right after the trap is tolerated; 6 onwards checks clean.
    step(0, 1, 5, 0, 0, 2, 0, 0, 1);
    for (int i = 6; i <= 9; i++) step(0, 1, 4'(i), 0, 0, 2, 0, 0, 1);
    step(0, 1, 0, 0, 0, 3, 0, 0, 1);
    step(0, 1, 1, 0, 1, 3, 0, 0, 2);

    // 3,4,6 breaks the sequence; resync and trap again.
    step(0, 1, 3, 0, 0, 2, 0, 0, 2);
    step(0, 1, 4, 0, 0, 2, 0, 0, 2);
    step(0, 1, 6, 0, 0, 2, 0, 0, 2);
    step(0, 1, 7, 0, 0, 1, 1, 0, 2);
    step(0, 1, 8, 0, 0, 2, 1, 0, 2);
    step(0, 1, 9, 0, 0, 2, 1, 0, 2);
    step(0, 1, 0, 0, 0, 3, 1, 0, 2);
    step(0, 1, 1, 0, 1, 3, 1, 0, 3);

    // Q=12 while armed.
    for (int i = 2; i <= 9; i++) step(0, 1, 4'(i), 0, 0, 2, 1, 0, 3);
    step(0, 1, 12, 0, 0, 3, 1, 0, 3);
    step(0, 1, 0, 0, 0, 1, 1, 1, 3);

    // Drop EN while armed (on the trap value), then reset during a trap.
    for (int i = 1; i <= 9; i++) step(0, 1, 4'(i), 0, 0, 2, 1, 1, 3);
    step(0, 1, 0, 0, 0, 3, 1, 1, 3);
    step(0, 0, 1, 0, 0, 3, 1, 1, 4);
    step(0, 0, 2, 0, 0, 0, 1, 1, 4);
    step(0, 1, 5, 0, 0, 0, 1, 1, 4);
    step(0, 1, 5, 0, 0, 1, 1, 1, 4);
    for (int i = 6; i <= 9; i++) step(0, 1, 4'(i), 0, 0, 2, 1, 1, 4);
    step(0, 1, 0, 0, 0, 3, 1, 1, 4);
    step(1, 1, 1, 0, 1, 3, 1, 1, 5);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Single-shot instance: one trap over three loops; 2-bit wrap saturates at 3.
    step(0, 1, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 9; i++) step(0, 1, 4'(i), 1, 0, 2, 0, 0, 0);
    step(0, 1, 0, 1, 0, 3, 0, 0, 0);
    step(0, 1, 1, 1, 1, 3, 0, 0, 1);
    for (int l = 0; l < 3; l++) begin
      for (int i = 2; i <= 9; i++) step(0, 1, 4'(i), 1, 0, 4, 0, 0, 8'(l + 1));
      step(0, 1, 0, 1, 0, 4, 0, 0, 8'(l + 1));
      step(0, 1, 1, 1, 0, 4, 0, 0, (l + 2 > 3) ? 8'd3 : 8'(l + 2));
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
